k423_if_stage: RTL and testbench

Instruction-fetch stage of the k423 core: owns the architectural fetch PC, issues requests on the instruction-memory port, buffers returned instructions in a small in-order fetch queue and presents them to the IF/ID pipe. It sits directly upstream of the IF/ID register and obeys the pipeline control unit's PC-stall and IF/ID-stall signals. It also takes branch and exception redirects from WB and squashes all wrong-path fetches, including responses still in flight.

---
 rtl/k423_if_stage_pkg.sv | 15 +
 rtl/k423_if_stage_if.sv | 13 +
 rtl/k423_if_stage_fifo.sv | 48 ++++
 rtl/k423_if_stage.sv | 114 +++++++++++
 tb/tb_k423_if_stage.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/k423_if_stage_pkg.sv
// Shared k423 fetch definitions: widths, reset PC, fetch-queue entry layout.
package k423_if_stage_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/k423_if_stage_if.sv
// Instruction-memory request/response port of the k423 fetch stage.
interface k423_if_stage_if;
  import k423_if_stage_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvld;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvld, rdata);
  modport slave  (input req, addr, output gnt, rvld, rdata);
endinterface

// File: rtl/k423_if_stage_fifo.sv
// Synchronous power-of-two FIFO with flush, occupancy count and full/empty flags.
module k423_if_stage_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] cnt_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  // Storage needs no reset; only count/pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/k423_if_stage.sv
// k423 instruction fetch: owns the fetch PC, issues credit-limited imem requests,
// buffers in-order responses and squashes wrong-path fetches on WB redirects.
module k423_if_stage
  import k423_if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int              FQ_DEPTH  = 2,
  parameter int              MAX_OUTST = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  k423_if_stage_if.master   imem,
  input  logic              wb_bju_br_tkn_i,
  input  logic [XLEN-1:0]   wb_bju_br_tgt_i,
  input  logic              wb_excp_br_tkn_i,
  input  logic [XLEN-1:0]   wb_excp_br_tgt_i,
  input  logic              pcu_stall_pc_i,
  input  logic              pcu_stall_if_id_i,
  output logic              if_vld_o,
  output logic [XLEN-1:0]   if_pc_o,
  output logic [ILEN-1:0]   if_inst_o
);
  localparam int FCW = $clog2(FQ_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTST) + 1;

  logic            redirect;
  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [OCW-1:0]  drop_q, drop_d;

  logic [FCW-1:0]  fq_cnt;
  logic            fq_full, fq_empty, fq_push, fq_pop;
  fq_entry_t       fq_wdata, fq_head;
  logic [FCW:0]    fq_used;

  logic [OCW-1:0]  outst_cnt;
  logic            ifl_full, ifl_empty;
  logic [XLEN-1:0] ifl_pc;
  logic            issue, fire;

  assign redirect  = wb_bju_br_tkn_i | wb_excp_br_tkn_i;
  assign redir_tgt = align_pc(wb_excp_br_tkn_i ? wb_excp_br_tgt_i : wb_bju_br_tgt_i);

  assign fq_pop = ~fq_empty & ~pcu_stall_if_id_i & ~redirect;
  // A slot freed by this cycle's pop can back a new request: its response lands next cycle at the earliest.
  assign fq_used = {1'b0, fq_cnt} + (FCW+1)'(outst_cnt) - (FCW+1)'(fq_pop);
  assign issue   = ~rst_i & ~pcu_stall_pc_i & ~redirect & ~ifl_full &
                   (fq_used < (FCW+1)'(FQ_DEPTH));
  assign fire    = issue & imem.gnt;

  assign imem.req  = issue;
  assign imem.addr = pc_q;

  assign fq_push  = imem.rvld & (drop_q == '0) & ~redirect;
  assign fq_wdata = '{pc: ifl_pc, inst: imem.rdata};

  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect) begin
      pc_d   = redir_tgt;
      // Everything still in flight after this edge belongs to the old path.
      drop_d = outst_cnt - OCW'(imem.rvld);
    end else begin
      if (fire) pc_d = pc_q + XLEN'(4);
      if (imem.rvld && drop_q != '0) drop_d = drop_q - OCW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  k423_if_stage_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(FQ_DEPTH)) u_fetch_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (fq_push),
    .data_i  (fq_wdata),
    .pop_i   (fq_pop),
    .data_o  (fq_head),
    .cnt_o   (fq_cnt),
    .full_o  (fq_full),
    .empty_o (fq_empty)
  );

  k423_if_stage_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_inflight_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .push_i  (fire),
    .data_i  (pc_q),
    .pop_i   (imem.rvld),
    .data_o  (ifl_pc),
    .cnt_o   (outst_cnt),
    .full_o  (ifl_full),
    .empty_o (ifl_empty)
  );

  assign if_vld_o  = ~fq_empty;
  assign if_pc_o   = fq_empty ? '0 : fq_head.pc;
  assign if_inst_o = fq_empty ? '0 : fq_head.inst;

  a_fq_room: assert property (@(posedge clk_i) disable iff (rst_i)
    fq_push |-> (!fq_full || fq_pop));
  a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    imem.rvld |-> !ifl_empty);
endmodule

// File: tb/tb_k423_if_stage.sv
// Scoreboard bench for k423_if_stage with a variable-latency in-order memory model.
module tb_k423_if_stage;
  import k423_if_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            bju_tkn, excp_tkn, stall_pc, stall_id;
  logic [XLEN-1:0] bju_tgt, excp_tgt;
  logic            if_vld;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_inst;

  k423_if_stage_if mif();

  k423_if_stage #(.RESET_PC(32'h8000_0000), .FQ_DEPTH(2), .MAX_OUTST(2)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .imem              (mif),
    .wb_bju_br_tkn_i   (bju_tkn),
    .wb_bju_br_tgt_i   (bju_tgt),
    .wb_excp_br_tkn_i  (excp_tkn),
    .wb_excp_br_tgt_i  (excp_tgt),
    .pcu_stall_pc_i    (stall_pc),
    .pcu_stall_if_id_i (stall_id),
    .if_vld_o          (if_vld),
    .if_pc_o           (if_pc),
    .if_inst_o         (if_inst)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  logic [XLEN-1:0] exp_pc_q [$];
  logic [XLEN-1:0] pend_addr [$];
  int              pend_due [$];

  function automatic logic [ILEN-1:0] inst_of(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [XLEN-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_pc_q.push_back(base + 32'(4 * i));
  endtask

  // Run until every expected instruction is consumed, then freeze IF/ID.
  task automatic drain(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (exp_pc_q.size() != 0 && n < 60);
    total++;
    if (exp_pc_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d left want 0 left", name, exp_pc_q.size());
      exp_pc_q.delete();
    end
    stall_id = 1'b1;
  endtask

  task automatic redirect_bju(input logic [XLEN-1:0] tgt);
    bju_tkn = 1'b1;
    bju_tgt = tgt;
    step();
    bju_tkn = 1'b0;
  endtask

  task automatic wait_inflight2(input string name);
    int n;
    n = 0;
    while ((pend_addr.size() + int'(mif.rvld)) != 2 && n < 12) begin
      step();
      n++;
    end
    check(name, 32'(pend_addr.size() + int'(mif.rvld)), 32'd2);
  endtask

  // Memory: samples the request at negedge, answers lat cycles after the grant edge.
  initial begin
    logic            fire_s, rst_s;
    logic [XLEN-1:0] a_s;
    mif.rvld  = 1'b0;
    mif.rdata = '0;
    forever begin
      @(negedge clk);
      fire_s = mif.req & mif.gnt;
      a_s    = mif.addr;
      rst_s  = rst;
      @(posedge clk);
      cyc++;
      if (rst_s || rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (fire_s) begin
        pend_addr.push_back(a_s);
        pend_due.push_back(cyc + lat - 1);
      end
      #1;
      if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mif.rvld  = 1'b1;
        mif.rdata = inst_of(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mif.rvld  = 1'b0;
        mif.rdata = '0;
      end
    end
  end

  // Monitor: every instruction IF/ID accepts must be the next expected one.
  always @(negedge clk) begin
    logic [XLEN-1:0] e;
    if (!rst && if_vld && !stall_id && !bju_tkn && !excp_tkn) begin
      if (exp_pc_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_inst: got pc %h want none", if_pc);
      end else begin
        e = exp_pc_q.pop_front();
        check("if_pc", if_pc, e);
        check("if_inst", if_inst, inst_of(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bju_tkn  = 1'b0;
    excp_tkn = 1'b0;
    bju_tgt  = '0;
    excp_tgt = '0;
    stall_pc = 1'b0;
    stall_id = 1'b0;
    mif.gnt  = 1'b1;
    rst      = 1'b1;
    step();
    step();
    #1;
    check("rst_req", 32'(mif.req), 32'd0);
    check("rst_vld", 32'(if_vld), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_inst", if_inst, 32'd0);

    // Streaming from reset, single-cycle memory
    push_exp(32'h8000_0000, 8);
    rst = 1'b0;
    #1;
    check("first_req", 32'(mif.req), 32'd1);
    check("first_addr", mif.addr, 32'h8000_0000);
    check("c0_vld", 32'(if_vld), 32'd0);
    step(); #1;
    check("c1_addr", mif.addr, 32'h8000_0004);
    check("c1_vld", 32'(if_vld), 32'd0);
    step(); #1;
    check("c2_addr", mif.addr, 32'h8000_0008);
    check("c2_vld", 32'(if_vld), 32'd1);
    check("c2_pc", if_pc, 32'h8000_0000);
    drain("stream");

    // IF/ID stall fills the queue and throttles requests
    repeat (5) step();
    #1;
    check("stall_req_drop", 32'(mif.req), 32'd0);
    check("stall_vld_hold", 32'(if_vld), 32'd1);
    stall_id = 1'b0;
    push_exp(32'h8000_0020, 6);
    drain("stall_release");

    // BJU redirect with two responses in flight
    lat = 2;
    repeat (3) step();
    redirect_bju(32'h8000_0200);
    wait_inflight2("bju_inflight");
    redirect_bju(32'h8000_0100);
    #1;
    check("bju_vld_low", 32'(if_vld), 32'd0);
    check("bju_req", 32'(mif.req), 32'd1);
    check("bju_addr", mif.addr, 32'h8000_0100);
    stall_id = 1'b0;
    push_exp(32'h8000_0100, 4);
    drain("bju");

    // Exception beats BJU; target low bits ignored
    repeat (4) step();
    bju_tkn  = 1'b1;
    bju_tgt  = 32'h0000_0100;
    excp_tkn = 1'b1;
    excp_tgt = 32'h8000_0005;
    step();
    bju_tkn  = 1'b0;
    excp_tkn = 1'b0;
    #1;
    check("excp_vld_low", 32'(if_vld), 32'd0);
    check("excp_req", 32'(mif.req), 32'd1);
    check("excp_addr", mif.addr, 32'h8000_0004);
    stall_id = 1'b0;
    push_exp(32'h8000_0004, 4);
    drain("excp");

    // Grant withheld, then PC stall
    lat = 1;
    repeat (4) step();
    mif.gnt = 1'b0;
    redirect_bju(32'h8000_0300);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("nognt_req", 32'(mif.req), 32'd1);
      check("nognt_addr", mif.addr, 32'h8000_0300);
      step();
    end
    stall_pc = 1'b1;
    #1;
    check("stallpc_req", 32'(mif.req), 32'd0);
    mif.gnt = 1'b1;
    step();
    step();
    #1;
    check("stallpc_req_held", 32'(mif.req), 32'd0);
    check("stallpc_pc_held", mif.addr, 32'h8000_0300);
    stall_pc = 1'b0;
    #1;
    check("unstall_req", 32'(mif.req), 32'd1);
    check("unstall_addr", mif.addr, 32'h8000_0300);
    stall_id = 1'b0;
    push_exp(32'h8000_0300, 4);
    drain("gnt_pc_stall");

    // Reset with two requests outstanding
    repeat (4) step();
    lat = 2;
    redirect_bju(32'h8000_0400);
    wait_inflight2("rst_inflight");
    rst = 1'b1;
    #1;
    check("midrst_req", 32'(mif.req), 32'd0);
    check("midrst_vld", 32'(if_vld), 32'd0);
    check("midrst_pc", if_pc, 32'd0);
    check("midrst_inst", if_inst, 32'd0);
    step();
    step();
    rst      = 1'b0;
    lat      = 1;
    stall_id = 1'b0;
    push_exp(32'h8000_0000, 4);
    #1;
    check("restart_req", 32'(mif.req), 32'd1);
    check("restart_addr", mif.addr, 32'h8000_0000);
    drain("restart");

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
